cn_min_sched: RTL and testbench

Check-node scheduler for the shared 5-input min unit (`min`, ports `msg_1`..`msg_5` -> `msg`) in the LDPC decoder check-node stage. It accepts a serial stream of 11-bit variable-to-check messages, groups them five per check node, and drives the min unit's operands. It captures the result and presents one registered minimum per check node on a valid/ready output, walking a check-node index that wraps once per frame.

---
 rtl/cn_min_sched.sv | 112 +++++++++++
 tb/tb_cn_min_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cn_min_sched.sv
// Check-node scheduler: gathers five serial messages per check node, drives the shared min unit,
// and presents one registered minimum per check node with a wrapping check-node index.
module cn_min_sched #(
  parameter int W   = 11,
  parameter int NCN = 8,
  parameter int CW  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_msg,
  output logic [W-1:0]  min_msg_1,
  output logic [W-1:0]  min_msg_2,
  output logic [W-1:0]  min_msg_3,
  output logic [W-1:0]  min_msg_4,
  output logic [W-1:0]  min_msg_5,
  input  logic [W-1:0]  min_msg,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_msg,
  output logic [CW-1:0] out_cn,
  output logic          frame_done
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_EVAL    = 2'd1;
  localparam logic [1:0] S_OUT     = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [W-1:0]  op_q [5];
  logic [W-1:0]  op_d [5];
  logic [W-1:0]  out_msg_q, out_msg_d;
  logic [CW-1:0] out_cn_q, out_cn_d;
  logic          fd_q, fd_d;
  logic          in_rdy_q, in_rdy_d;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    op_d      = op_q;
    out_msg_d = out_msg_q;
    out_cn_d  = out_cn_q;
    fd_d      = 1'b0;
    case (state_q)
      S_COLLECT: begin
        if (in_valid && in_rdy_q) begin
          for (int i = 0; i < 5; i++) begin
            if (k_q == 3'(i)) op_d[i] = in_msg;
          end
          if (k_q == 3'd4) begin
            k_d     = 3'd0;
            state_d = S_EVAL;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      S_EVAL: begin
        out_msg_d = min_msg;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_COLLECT;
          // frame_done pulses on the same edge the index wraps
          if (out_cn_q == CW'(NCN - 1)) begin
            out_cn_d = '0;
            fd_d     = 1'b1;
          end else begin
            out_cn_d = out_cn_q + CW'(1);
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase
    in_rdy_d = (state_d == S_COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_COLLECT;
      k_q       <= 3'd0;
      for (int i = 0; i < 5; i++) op_q[i] <= '0;
      out_msg_q <= '0;
      out_cn_q  <= '0;
      fd_q      <= 1'b0;
      in_rdy_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      op_q      <= op_d;
      out_msg_q <= out_msg_d;
      out_cn_q  <= out_cn_d;
      fd_q      <= fd_d;
      in_rdy_q  <= in_rdy_d;
    end
  end

  assign in_ready   = in_rdy_q;
  assign out_valid  = (state_q == S_OUT);
  assign out_msg    = out_msg_q;
  assign out_cn     = out_cn_q;
  assign frame_done = fd_q;
  assign min_msg_1  = op_q[0];
  assign min_msg_2  = op_q[1];
  assign min_msg_3  = op_q[2];
  assign min_msg_4  = op_q[3];
  assign min_msg_5  = op_q[4];

endmodule

// File: tb/tb_cn_min_sched.sv
// Bench for cn_min_sched: directed and random groups against a group-minimum reference model.
module tb_cn_min_sched;

  localparam int W   = 11;
  localparam int NCN = 8;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_msg;
  logic [W-1:0]  min_msg_1, min_msg_2, min_msg_3, min_msg_4, min_msg_5;
  logic [W-1:0]  min_msg;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_msg;
  logic [CW-1:0] out_cn;
  logic          frame_done;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  int cn_exp  = 0;
  logic [W-1:0] grp [5];
  logic [W-1:0] ops [5];

  cn_min_sched #(.W(W), .NCN(NCN), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
    .min_msg_1(min_msg_1), .min_msg_2(min_msg_2), .min_msg_3(min_msg_3),
    .min_msg_4(min_msg_4), .min_msg_5(min_msg_5), .min_msg(min_msg),
    .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg),
    .out_cn(out_cn), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // attached min unit (unsigned)
  logic [W-1:0] m12, m34, m1234;
  assign m12     = (min_msg_1 < min_msg_2) ? min_msg_1 : min_msg_2;
  assign m34     = (min_msg_3 < min_msg_4) ? min_msg_3 : min_msg_4;
  assign m1234   = (m12 < m34) ? m12 : m34;
  assign min_msg = (m1234 < min_msg_5) ? m1234 : min_msg_5;

  assign ops[0] = min_msg_1;
  assign ops[1] = min_msg_2;
  assign ops[2] = min_msg_3;
  assign ops[3] = min_msg_4;
  assign ops[4] = min_msg_5;

  function automatic logic [W-1:0] ref_min(input logic [W-1:0] m [5]);
    logic [W-1:0] r;
    r = m[0];
    for (int i = 1; i < 5; i++) if (m[i] < r) r = m[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [W-1:0] v);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_msg   = v;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("rdy_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_group(input logic [W-1:0] m [5], input int gap_at, input int gap_len,
                           input int hold);
    int t0;
    logic [W-1:0] e;
    t0 = cyc;
    e  = ref_min(m);
    for (int i = 0; i < 5; i++) begin
      send(m[i]);
      if (i == 0) chk("fd_single", {31'd0, frame_done}, 32'd0);
      if (i == gap_at) begin
        for (int j = 0; j < gap_len; j++) begin
          @(negedge clk);
          chk("rdy_gap", {31'd0, in_ready}, 32'd1);
        end
      end
    end
    chk("eval_vld", {31'd0, out_valid}, 32'd0);
    chk("eval_rdy", {31'd0, in_ready}, 32'd0);
    for (int j = 0; j < 5; j++) chk("operand", {21'd0, ops[j]}, {21'd0, m[j]});
    @(negedge clk);
    chk("lat_vld", {31'd0, out_valid}, 32'd1);
    chk("out_msg", {21'd0, out_msg}, {21'd0, e});
    chk("out_cn", {29'd0, out_cn}, cn_exp);
    chk("out_rdy", {31'd0, in_ready}, 32'd0);
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int j = 0; j < hold; j++) begin
        @(negedge clk);
        chk("hold_vld", {31'd0, out_valid}, 32'd1);
        chk("hold_msg", {21'd0, out_msg}, {21'd0, e});
        chk("hold_cn", {29'd0, out_cn}, cn_exp);
        chk("hold_rdy", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    if (gap_len == 0 && hold == 0) chk("cycles_per_cn", cyc - t0, 32'd7);
    chk("post_vld", {31'd0, out_valid}, 32'd0);
    chk("post_rdy", {31'd0, in_ready}, 32'd1);
    chk("cn_next", {29'd0, out_cn}, (cn_exp + 1) % NCN);
    chk("frame_done", {31'd0, frame_done}, (cn_exp == NCN - 1) ? 32'd1 : 32'd0);
    cn_exp = (cn_exp + 1) % NCN;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {31'd0, in_ready}, 32'd0);
    chk(tag, {31'd0, out_valid}, 32'd0);
    chk(tag, {31'd0, frame_done}, 32'd0);
    chk(tag, {21'd0, out_msg}, 32'd0);
    chk(tag, {29'd0, out_cn}, 32'd0);
    for (int j = 0; j < 5; j++) chk(tag, {21'd0, ops[j]}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_msg    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", {31'd0, in_ready}, 32'd1);

    // back-to-back group
    grp = '{11'h1A7, 11'h2BA, 11'h0A8, 11'h0B2, 11'h0A9};
    run_group(grp, 9, 0, 0);
    // same group with a 3-cycle gap after the 2nd message
    run_group(grp, 1, 3, 0);
    // output backpressure for 10 cycles
    grp = '{11'h333, 11'h222, 11'h444, 11'h555, 11'h666};
    run_group(grp, 9, 0, 10);

    // reset in the middle of a group
    send(11'h050);
    send(11'h060);
    send(11'h070);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst2", {31'd0, in_ready}, 32'd1);
    cn_exp = 0;
    grp = '{11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h001};
    run_group(grp, 9, 0, 0);

    // boundary values
    grp = '{11'h000, 11'h000, 11'h000, 11'h000, 11'h000};
    run_group(grp, 9, 0, 0);
    grp = '{11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF};
    run_group(grp, 9, 0, 0);

    // random groups to finish the frame, with random gaps and backpressure
    while (cn_exp != 0) begin
      for (int j = 0; j < 5; j++) grp[j] = W'($urandom_range(0, 2047));
      run_group(grp, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)));
    end

    // full frame: group g all equal to 0x100+g
    for (int g = 0; g < NCN; g++) begin
      for (int j = 0; j < 5; j++) grp[j] = W'(11'h100 + g);
      run_group(grp, 9, 0, 0);
    end
    @(negedge clk);
    chk("fd_drop", {31'd0, frame_done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
